// File: rtl/sram_arb_pkg.sv
// Shared widths, request bundle and strobe-to-mask helper for the SRAM port arbiter.
// No logic state; pure types and a combinational function.
// No flow control lives here.
package sram_arb_pkg;

    localparam int SRAM_AW   = 14;
    localparam int SRAM_DW   = 32;
    localparam int SRAM_STRB = SRAM_DW / 8;

    typedef struct packed {
        logic                 we;
        logic [SRAM_AW-1:0]   addr;
        logic [SRAM_DW-1:0]   wdata;
        logic [SRAM_STRB-1:0] wstrb;
    } sram_req_t;

    // Byte strobes (active-high) to the macro's per-bit write mask (active-low).
    function automatic logic [SRAM_DW-1:0] strb2bweb(input logic [SRAM_STRB-1:0] strb);
        logic [SRAM_DW-1:0] m;
        m = '1;
        for (int b = 0; b < SRAM_STRB; b++) begin
            m[b*8 +: 8] = {8{~strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one eligible requester, searching from rr_ptr+1 upward.
// Latency: purely combinational.
// Backpressure: none; callers mask ineligible requesters before the search.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && elig[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM among NREQ requesters, one access per cycle; SRAM_ARB_LOCK_EN adds grant locking.
// Latency: write completes on handshake; read data reaches rsp_valid 2 edges after handshake.
// Backpressure: a read is held off while its requester has a read in flight or an unaccepted response.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = SRAM_AW,
    parameter int DW   = SRAM_DW
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    input  logic [NREQ*DW/8-1:0] req_wstrb,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*DW-1:0]   rsp_data,
    output logic                 sram_ceb,
    output logic                 sram_web,
    output logic [AW-1:0]        sram_a,
    output logic [DW-1:0]        sram_d,
    output logic [DW-1:0]        sram_bweb,
    input  logic [DW-1:0]        sram_q
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = DW / 8;

    logic [IW-1:0]   rr_q, rr_d;
    logic [NREQ-1:0] inflight_q, inflight_d;
    logic [NREQ-1:0] hold_vld_q, hold_vld_d;
    logic [DW-1:0]   hold_dat_q [NREQ];
    logic [DW-1:0]   hold_dat_d [NREQ];
    logic [AW-1:0]   a_q, a_d;
    logic [DW-1:0]   d_q, d_d;

    logic [NREQ-1:0] elig, elig_m, gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_vld;
    sram_req_t       sel;

    // Reset forces every request ineligible, which in turn holds req_ready low.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && !ARESET &&
                      (req_we[i] || (!inflight_q[i] && (!hold_vld_q[i] || rsp_ready[i])));
        end
    end

`ifdef SRAM_ARB_LOCK_EN
    logic          lock_q, lock_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        elig_m     = elig;
        if (lock_q) begin
            for (int i = 0; i < NREQ; i++) begin
                elig_m[i] = elig[i] && (IW'(i) == lock_idx_q);
            end
        end
        if (gnt_vld) begin
            lock_d     = req_lock[gnt_idx];
            lock_idx_d = gnt_idx;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    logic lock_unused;
    assign lock_unused = ^req_lock;
    assign elig_m      = elig;
`endif

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
        .elig    (elig_m),
        .rr_ptr  (rr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_vld   = |gnt;
    assign req_ready = gnt;

    always_comb begin
        sel       = '0;
        sel.we    = req_we[gnt_idx];
        sel.addr  = req_addr[int'(gnt_idx)*AW +: AW];
        sel.wdata = req_wdata[int'(gnt_idx)*DW +: DW];
        sel.wstrb = req_wstrb[int'(gnt_idx)*SW +: SW];
    end

    // Address and data buses keep their last driven value while idle.
    always_comb begin
        sram_ceb  = !gnt_vld;
        sram_web  = !(gnt_vld && sel.we);
        sram_a    = gnt_vld ? sel.addr  : a_q;
        sram_d    = gnt_vld ? sel.wdata : d_q;
        sram_bweb = (gnt_vld && sel.we) ? strb2bweb(sel.wstrb) : '1;
    end

    always_comb begin
        rr_d       = gnt_vld ? gnt_idx : rr_q;
        a_d        = sram_a;
        d_d        = sram_d;
        inflight_d = gnt & ~req_we;
        hold_vld_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            hold_dat_d[i] = hold_dat_q[i];
            hold_vld_d[i] = inflight_q[i] || (hold_vld_q[i] && !rsp_ready[i]);
            if (inflight_q[i]) begin
                hold_dat_d[i] = sram_q;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rr_q       <= IW'(NREQ - 1);
            inflight_q <= '0;
            hold_vld_q <= '0;
            a_q        <= '0;
            d_q        <= '0;
            for (int i = 0; i < NREQ; i++) begin
                hold_dat_q[i] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            hold_vld_q <= hold_vld_d;
            a_q        <= a_d;
            d_q        <= d_d;
            for (int i = 0; i < NREQ; i++) begin
                hold_dat_q[i] <= hold_dat_d[i];
            end
        end
    end

    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_data[i*DW +: DW] = hold_dat_q[i];
        end
    end

    assign rsp_valid = hold_vld_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a scoreboard monitor.
// Define SRAM_ARB_LOCK_EN on both RTL and bench to exercise grant locking.
module tb_sram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 14;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_we, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*4-1:0]  req_wstrb;
    logic [N-1:0]    rsp_valid, rsp_ready;
    logic [N*DW-1:0] rsp_data;
    logic            sram_ceb, sram_web;
    logic [AW-1:0]   sram_a;
    logic [DW-1:0]   sram_d, sram_bweb, sram_q;

    always #5 clk = ~clk;

    sram_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .ACLK      (clk),
        .ARESET    (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_bweb (sram_bweb),
        .sram_q    (sram_q)
    );

    // Behavioural single-port macro, pre-zeroed, 1-cycle read latency.
    logic [DW-1:0] mem [int];
    always @(posedge clk) begin
        if (!sram_ceb) begin
            logic [DW-1:0] old;
            old = mem.exists(int'(sram_a)) ? mem[int'(sram_a)] : '0;
            if (!sram_web) mem[int'(sram_a)] = (old & sram_bweb) | (sram_d & ~sram_bweb);
            else           sram_q <= old;
        end
    end

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] bweb;
        int            idx;
    } acc_t;

    acc_t          acc_q [$];
    logic [DW-1:0] rsp_q0 [$];
    logic [DW-1:0] rsp_q1 [$];
    logic [DW-1:0] rsp_q2 [$];

    function automatic void push_acc(logic we, logic [AW-1:0] a, logic [DW-1:0] d,
                                     logic [DW-1:0] bweb, int idx);
        acc_t e;
        e.we = we; e.a = a; e.d = d; e.bweb = bweb; e.idx = idx;
        acc_q.push_back(e);
    endfunction

    function automatic void push_rsp(int i, logic [DW-1:0] d);
        case (i)
            0:       rsp_q0.push_back(d);
            1:       rsp_q1.push_back(d);
            default: rsp_q2.push_back(d);
        endcase
    endfunction

    function automatic int rsp_pending();
        return rsp_q0.size() + rsp_q1.size() + rsp_q2.size();
    endfunction

    // Monitor: every SRAM access and every response handshake is scored in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (!sram_ceb) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_access_addr", {1'b1, sram_a}, 64'h0);
                end else begin
                    acc_t e;
                    logic [N-1:0] exp_rdy;
                    e = acc_q.pop_front();
                    exp_rdy = '0;
                    exp_rdy[e.idx] = 1'b1;
                    chk("grant_onehot", req_ready, exp_rdy);
                    chk("sram_web", sram_web, !e.we);
                    chk("sram_a", sram_a, e.a);
                    chk("sram_bweb", sram_bweb, e.bweb);
                    if (e.we) chk("sram_d", sram_d, e.d);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    logic [DW-1:0] exp_d;
                    logic          have;
                    have  = 1'b0;
                    exp_d = '0;
                    case (i)
                        0: if (rsp_q0.size() > 0) begin exp_d = rsp_q0.pop_front(); have = 1'b1; end
                        1: if (rsp_q1.size() > 0) begin exp_d = rsp_q1.pop_front(); have = 1'b1; end
                        default: if (rsp_q2.size() > 0) begin exp_d = rsp_q2.pop_front(); have = 1'b1; end
                    endcase
                    if (have) chk($sformatf("rsp_data%0d", i), rsp_data[i*DW +: DW], exp_d);
                    else      chk($sformatf("unexpected_rsp%0d", i), {1'b1, rsp_data[i*DW +: DW]}, 64'h0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic v, logic we, logic lk, logic [AW-1:0] a,
                           logic [DW-1:0] d, logic [3:0] s);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_lock[i]           = lk;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*4 +: 4]   = s;
    endtask

    // Wait (bounded) for requester i's handshake; returns just after that edge.
    task automatic wait_hs(int i, logic drop);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[i]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout req=%0d actual=no_grant required=grant", i);
        end
        step();
        if (drop) req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 30 && (acc_q.size() + rsp_pending()) != 0; c++) step();
        chk("acc_q_drained", acc_q.size(), 0);
        chk("rsp_q_drained", rsp_pending(), 0);
    endtask

    task automatic all_writes(logic v);
        for (int i = 0; i < N; i++)
            set_req(i, v, 1'b1, 1'b0, AW'(14'h100 + i), 32'hA000_0000 + i, 4'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0; req_we = '0; req_lock = '0;
        req_addr  = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = '1;
        repeat (2) step();
        rst = 1'b0;

        // Reset state, then idle.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("idle_ceb", sram_ceb, 1'b1);
            chk("idle_web", sram_web, 1'b1);
            chk("idle_bweb", sram_bweb, 32'hFFFF_FFFF);
            chk("idle_rsp_valid", rsp_valid, 3'b000);
            chk("idle_a", sram_a, 14'h0);
            chk("idle_d", sram_d, 32'h0);
        end
        step();

        // Continuous writes from everyone: strict rotation 0,1,2,0,1,2.
        for (int r = 0; r < 6; r++)
            push_acc(1'b1, AW'(14'h100 + (r % 3)), 32'hA000_0000 + (r % 3), 32'h0, r % 3);
        all_writes(1'b1);
        repeat (6) step();
        all_writes(1'b0);
        drain();

        // Partial-strobe write then read-back with 2-edge latency.
        push_acc(1'b1, 14'h10, 32'hDEAD_BEEF, 32'hFF00_FF00, 1);
        set_req(1, 1'b1, 1'b1, 1'b0, 14'h10, 32'hDEAD_BEEF, 4'b0101);
        wait_hs(1, 1'b1);
        push_acc(1'b1, 14'h20, 32'h1234_5678, 32'h0, 1);
        set_req(1, 1'b1, 1'b1, 1'b0, 14'h20, 32'h1234_5678, 4'hF);
        wait_hs(1, 1'b1);
        push_acc(1'b0, 14'h10, 32'h0, 32'hFFFF_FFFF, 0);
        push_rsp(0, 32'h00AD_00EF);
        set_req(0, 1'b1, 1'b0, 1'b0, 14'h10, 32'h0, 4'h0);
        wait_hs(0, 1'b1);
        @(negedge clk);
        chk("rd_lat_edge1_rsp_valid0", rsp_valid[0], 1'b0);
        @(negedge clk);
        chk("rd_lat_edge2_rsp_valid0", rsp_valid[0], 1'b1);
        step();
        drain();

        // Held response blocks a second read from the same requester.
        rsp_ready[2] = 1'b0;
        push_acc(1'b0, 14'h10, 32'h0, 32'hFFFF_FFFF, 2);
        push_rsp(2, 32'h00AD_00EF);
        set_req(2, 1'b1, 1'b0, 1'b0, 14'h10, 32'h0, 4'h0);
        wait_hs(2, 1'b0);
        set_req(2, 1'b1, 1'b0, 1'b0, 14'h20, 32'h0, 4'h0);
        push_acc(1'b0, 14'h20, 32'h0, 32'hFFFF_FFFF, 2);
        push_rsp(2, 32'h1234_5678);
        @(negedge clk);
        chk("inflight_blocks_rd2", req_ready[2], 1'b0);
        chk("inflight_rsp_valid2", rsp_valid[2], 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("held_rsp_valid2", rsp_valid[2], 1'b1);
            chk("held_rsp_data2", rsp_data[2*DW +: DW], 32'h00AD_00EF);
            chk("held_blocks_rd2", req_ready[2], 1'b0);
        end
        step();
        rsp_ready[2] = 1'b1;
        @(negedge clk);
        chk("accept_same_cycle_grant2", req_ready[2], 1'b1);
        step();
        req_valid[2] = 1'b0;
        drain();

        // Reset the cycle after a read grant: no response, rotation restarts at 0.
        push_acc(1'b0, 14'h20, 32'h0, 32'hFFFF_FFFF, 0);
        set_req(0, 1'b1, 1'b0, 1'b0, 14'h20, 32'h0, 4'h0);
        wait_hs(0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_discard_rsp_valid", rsp_valid, 3'b000);
        end
        step();
        for (int r = 0; r < 3; r++)
            push_acc(1'b1, AW'(14'h100 + r), 32'hA000_0000 + r, 32'h0, r);
        all_writes(1'b1);
        repeat (3) step();
        all_writes(1'b0);
        drain();

`ifdef SRAM_ARB_LOCK_EN
        // Locked read-modify-write from 1 stays contiguous amid 0 and 2.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        push_acc(1'b1, 14'h100, 32'hA000_0000, 32'h0, 0);
        push_acc(1'b0, 14'h40, 32'h0, 32'hFFFF_FFFF, 1);
        push_acc(1'b1, 14'h40, 32'h5555_AAAA, 32'h0, 1);
        push_acc(1'b1, 14'h102, 32'hA000_0002, 32'h0, 2);
        push_acc(1'b1, 14'h100, 32'hA000_0000, 32'h0, 0);
        push_rsp(1, 32'h0);
        all_writes(1'b1);
        set_req(1, 1'b1, 1'b0, 1'b1, 14'h40, 32'h0, 4'h0);
        repeat (2) step();
        set_req(1, 1'b1, 1'b1, 1'b0, 14'h40, 32'h5555_AAAA, 4'hF);
        step();
        req_valid[1] = 1'b0;
        repeat (2) step();
        all_writes(1'b0);
        req_valid[1] = 1'b0;
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin arbiter and sequencer that shares one single-port SRAM macro (active-low CEB/WEB/BWEB, 1-cycle read latency) among NREQ word-wide requesters, such as an AXI slave read engine, an AXI write engine and a fill/scrub engine. It issues at most one SRAM access per cycle. It tracks one outstanding read per requester and holds each read result in a per-requester response register until that requester accepts it. It sits between the SRAM_wrapper-style protocol front ends and the TS1N16 macro instance.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- AW, 14, SRAM word-address width
- DW, 32, data width; strobe width is DW/8

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  access request per requester
- req_ready  out  NREQ  grant/accept; handshake when valid&ready
- req_we  in  NREQ  1 = write, 0 = read
- req_lock  in  NREQ  hold grant after this beat (used only with SRAM_ARB_LOCK_EN)
- req_addr  in  NREQ*AW  word index, slice i
- req_wdata  in  NREQ*DW  write data, slice i
- req_wstrb  in  NREQ*DW/8  byte enables, active-high
- rsp_valid  out  NREQ  read data available
- rsp_ready  in  NREQ  read data accepted
- rsp_data  out  NREQ*DW  read data, slice i
- sram_ceb  out  1  chip enable, active-low
- sram_web  out  1  0 = write
- sram_a  out  AW  word address
- sram_d  out  DW  write data
- sram_bweb  out  DW  per-bit write mask, active-low
- sram_q  in  DW  macro read data, valid the cycle after a read

## Operation
- Eligibility of requester i:
  - Requires req_valid[i].
  - A read additionally requires that no read of i is in flight, and that either no response is held for i or the held response is accepted this cycle (rsp_valid[i]&rsp_ready[i]).
  - A write is always eligible.
- Arbitration:
  - Round-robin over eligible requesters; the search starts at rr_q+1 mod NREQ.
  - rr_q updates to the granted index on each handshake; rr_q resets to NREQ-1, so requester 0 wins first.
  - At most one grant per cycle.
  - req_ready is combinational from the grant and may depend on req_valid.
- Worst-case wait for a continuously eligible requester without lock: NREQ-1 grants.
- SRAM drive:
  - On a grant: sram_ceb=0, sram_web=~req_we[g], sram_a=req_addr[g], sram_d=req_wdata[g].
  - For a write, sram_bweb = ~(each strobe bit replicated 8 times). For a read, sram_bweb is all ones.
  - With no grant: ceb=1, web=1, bweb all ones, a and d hold their last driven value.
- Writes are fire-and-forget: no response, and they complete on the handshake.
- Reads: a read granted in cycle t sets inflight[i]. In t+1, rsp_valid[i]=1 and rsp_data[i]=sram_q captured into the hold register, and inflight[i] clears.
- A held response stays stable until rsp_ready[i]; rsp_valid[i] then drops the next cycle unless a new read result lands in that same cycle.
- Responses to different requesters are independent; they never block each other.

## Timing
- Read latency is 2 edges from handshake to rsp_valid (hold register after the SRAM Q). Write latency is 1 edge.
- Back-to-back reads by one requester are possible every 2 cycles, provided rsp_ready is held high.
- Reads from different requesters can be issued in consecutive cycles, one per cycle.
- Reset (ARESET sampled high):
  - rr_q=NREQ-1; inflight, hold-valid and lock state cleared.
  - Outputs: rsp_valid=0, rsp_data=0, req_ready=0 (forced during reset), sram_ceb=1, sram_web=1, sram_bweb all ones, sram_a=0, sram_d=0.
  - An in-flight read is discarded and no response is produced.
- A read and a write contend only through arbitration; no read-after-write forwarding is needed because the macro serialises accesses.

## Configuration
- Macro SRAM_ARB_LOCK_EN.
- Defined:
  - A handshake with req_lock[g]=1 locks arbitration to g; only g is eligible until a handshake from g with req_lock[g]=0.
  - rr_q still updates normally.
  - Intended for atomic read-modify-write and for keeping bursts contiguous.
- Undefined: the req_lock port is present but ignored, and no lock register is synthesised.

## Structure
- Package sram_arb_pkg:
  - SRAM_AW=14, SRAM_DW=32, SRAM_STRB=4.
  - Function strb2bweb(strb), returning the active-low bit mask.
  - Typedef sram_req_t {we, addr, wdata, wstrb}.
- One sub-module, rr_arbiter:
  - Parameter N.
  - Inputs: eligible mask and rr pointer.
  - Outputs: one-hot grant and grant index.
- Lock masking, the SRAM mux and the response registers stay in the top module.

## Test plan
- Reset then idle: verify sram_ceb=1, sram_bweb=32'hFFFF_FFFF, rsp_valid=0 every cycle.
- Requester 1 writes addr 0x10, data 0xDEADBEEF, strb 4'b0101; then requester 0 reads 0x10 → sram_bweb=32'hFF00_FF00 on the write; rsp_data[0]=0x00AD00EF (pre-zeroed word), rsp_valid[0] 2 edges after the read handshake.
- All 3 requesters hold continuous writes → grant order 0,1,2,0,1,2…; no requester waits more than 2 cycles.
- Requester 2 reads with rsp_ready[2]=0 for 5 cycles → the data stays stable and a second read from 2 is not granted; the cycle rsp_ready rises, the new read is granted the same cycle.
- ARESET asserted the cycle after a read grant → no rsp_valid ever appears for that read; next grant goes to requester 0.
- With SRAM_ARB_LOCK_EN: requester 1 does read with lock=1, then write with lock=0, while 0 and 2 request continuously → the two beats from requester 1 are consecutive; then grants go to 2,0.
